// File: rtl/dll_index_ctrl.sv
// Purpose : closed-loop selection of the truncation index for the DLL accumulator truncator.
// Latency : a dump presented in cycle t can move index at the edge ending t+2 (visible in t+3).
// Backpressure: none; accepts acc_valid every cycle, no ready, no stalls.
//
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   init          - synchronous channel restart pulse (highest priority)
//   acc_valid     - acc_in carries a dump this cycle
//   acc_in[35:0]  - signed two's-complement accumulator dump
//   index[5:0]    - registered truncation index (window = in[index:index-10])
//   index_update  - one-cycle pulse in the cycle the new index first appears
//   tracking      - 1 in TRACK, 0 in ACQUIRE
//   ovf_total     - (only when DLL_INDEX_CTRL_STATS_EN is defined) saturating count
//                   of overflow-classified dumps since reset or init
//
// Optional feature macro: DLL_INDEX_CTRL_STATS_EN
module dll_index_ctrl #(
  parameter int INIT_INDEX   = 20,
  parameter int MIN_INDEX    = 10,
  parameter int MAX_INDEX    = 35,
  parameter int WINDOW       = 8,
  parameter int OVF_THRESH   = 2,
  parameter int UNDER_MARGIN = 2,
  parameter int ACQ_DUMPS    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init,
  input  logic        acc_valid,
  input  logic [35:0] acc_in,
  output logic [5:0]  index,
  output logic        index_update,
  output logic        tracking
`ifdef DLL_INDEX_CTRL_STATS_EN
  ,
  output logic [15:0] ovf_total
`endif
);

  typedef enum logic {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } state_t;

  localparam logic [5:0] INIT_C   = 6'(INIT_INDEX);
  localparam logic [6:0] MIN_C    = 7'(MIN_INDEX);
  localparam logic [6:0] MAX_C    = 7'(MAX_INDEX);
  localparam logic [6:0] UNDER_C  = 7'(UNDER_MARGIN + 1);
  localparam logic [7:0] WIN_C    = 8'(WINDOW);
  localparam logic [7:0] OVF_TH_C = 8'(OVF_THRESH);
  localparam logic [7:0] ACQ_C    = 8'(ACQ_DUMPS);

  // Highest set bit of an unsigned magnitude; zero maps to 0.
  function automatic logic [5:0] msb_pos(input logic [35:0] m);
    logic [5:0] pos;
    pos = '0;
    for (int i = 0; i < 36; i++) begin
      if (m[i]) pos = 6'(i);
    end
    return pos;
  endfunction

  // ---------------------------------------------------------------
  // S1: magnitude. Negating -2^35 wraps to bit 35 set, which read as
  // unsigned is exactly 2^35, so no special case is needed.
  // ---------------------------------------------------------------
  logic [35:0] mag_c;
  logic        s1_vld;
  logic [35:0] s1_mag;

  assign mag_c = acc_in[35] ? (~acc_in + 36'd1) : acc_in;

  // S2: MSB position of the magnitude.
  logic       s2_vld;
  logic [5:0] s2_p;

  // ---------------------------------------------------------------
  // S3: classification and control state
  // ---------------------------------------------------------------
  state_t     state_q, state_d;
  logic [5:0] index_d;
  logic       upd_d;
  logic [7:0] good_q, good_d;
  logic [7:0] dump_q, dump_d;
  logic [7:0] ovfc_q, ovfc_d;
  logic [7:0] underc_q, underc_d;

  logic [6:0] p_ext;
  logic [6:0] idx_ext;
  logic [6:0] p_plus1;
  logic       ovf;
  logic       under;
  logic [5:0] acq_target;

  assign p_ext   = {1'b0, s2_p};
  assign idx_ext = {1'b0, index};
  assign p_plus1 = p_ext + 7'd1;

  // p > index-1 and p < index-1-UNDER_MARGIN, rearranged so nothing
  // can go negative on the unsigned operands.
  assign ovf   = (p_plus1 > idx_ext);
  assign under = ((p_ext + UNDER_C) < idx_ext);

  // Jump straight to the bit just above the observed MSB, clamped.
  always_comb begin
    acq_target = p_plus1[5:0];
    if (p_plus1 > MAX_C) begin
      acq_target = MAX_C[5:0];
    end else if (p_plus1 < MIN_C) begin
      acq_target = MIN_C[5:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    index_d  = index;
    good_d   = good_q;
    dump_d   = dump_q;
    ovfc_d   = ovfc_q;
    underc_d = underc_q;

    if (s2_vld) begin
      unique case (state_q)
        ACQUIRE: begin
          if (ovf) begin
            index_d = acq_target;
            good_d  = '0;
          end else if (good_q + 8'd1 >= ACQ_C) begin
            state_d  = TRACK;
            good_d   = '0;
            dump_d   = '0;
            ovfc_d   = '0;
            underc_d = '0;
          end else begin
            good_d = good_q + 8'd1;
          end
        end
        TRACK: begin
          // The dump closing the window is folded into the counts first.
          dump_d   = dump_q + 8'd1;
          ovfc_d   = ovfc_q + {7'd0, ovf};
          underc_d = underc_q + {7'd0, under};
          if (dump_d == WIN_C) begin
            if (ovfc_d >= OVF_TH_C) begin
              if (idx_ext < MAX_C) index_d = index + 6'd1;
            end else if (underc_d == WIN_C) begin
              if (idx_ext > MIN_C) index_d = index - 6'd1;
            end
            dump_d   = '0;
            ovfc_d   = '0;
            underc_d = '0;
          end
        end
        default: state_d = ACQUIRE;
      endcase
    end

    // A clamped (blocked) step leaves index_d equal to index: no pulse.
    upd_d = (index_d != index);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld       <= 1'b0;
      s1_mag       <= '0;
      s2_vld       <= 1'b0;
      s2_p         <= '0;
      state_q      <= ACQUIRE;
      index        <= INIT_C;
      index_update <= 1'b0;
      good_q       <= '0;
      dump_q       <= '0;
      ovfc_q       <= '0;
      underc_q     <= '0;
    end else if (init) begin
      // Restart: the pipeline is flushed so in-flight dumps are lost,
      // and the dump offered alongside init is never captured.
      s1_vld       <= 1'b0;
      s2_vld       <= 1'b0;
      state_q      <= ACQUIRE;
      index        <= INIT_C;
      index_update <= 1'b0;
      good_q       <= '0;
      dump_q       <= '0;
      ovfc_q       <= '0;
      underc_q     <= '0;
    end else begin
      s1_vld       <= acc_valid;
      s1_mag       <= mag_c;
      s2_vld       <= s1_vld;
      s2_p         <= msb_pos(s1_mag);
      state_q      <= state_d;
      index        <= index_d;
      index_update <= upd_d;
      good_q       <= good_d;
      dump_q       <= dump_d;
      ovfc_q       <= ovfc_d;
      underc_q     <= underc_d;
    end
  end

  assign tracking = (state_q == TRACK);

`ifdef DLL_INDEX_CTRL_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_total <= '0;
    end else if (init) begin
      ovf_total <= '0;
    end else if (s2_vld && ovf && (ovf_total != 16'hFFFF)) begin
      ovf_total <= ovf_total + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dll_index_ctrl.sv
// Purpose : self-checking bench for dll_index_ctrl against a behavioural model.
// Latency : model applies each dump two edges after it is presented.
// Backpressure: none; stimulus drives acc_valid freely.
module tb_dll_index_ctrl;

  localparam int INIT_I = 20;
  localparam int MIN_I  = 10;
  localparam int MAX_I  = 35;
  localparam int WIN    = 8;
  localparam int OVF_TH = 2;
  localparam int UM     = 2;
  localparam int ACQ    = 4;

  logic        clk;
  logic        reset_n;
  logic        init;
  logic        acc_valid;
  logic [35:0] acc_in;
  logic [5:0]  index;
  logic        index_update;
  logic        tracking;
`ifdef DLL_INDEX_CTRL_STATS_EN
  logic [15:0] ovf_total;
`endif

  int n_chk;
  int n_fail;

  dll_index_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .init         (init),
    .acc_valid    (acc_valid),
    .acc_in       (acc_in),
    .index        (index),
    .index_update (index_update),
    .tracking     (tracking)
`ifdef DLL_INDEX_CTRL_STATS_EN
    ,
    .ovf_total    (ovf_total)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_idx, m_good, m_dc, m_oc, m_uc, m_total;
  bit  m_trk, m_upd;
  bit  h_vld [2];
  logic signed [35:0] h_val [2];

  function automatic int msb_of(input logic signed [35:0] a);
    longint sv, mag;
    int p;
    sv  = longint'(a);
    mag = (sv < 0) ? -sv : sv;
    p   = 0;
    for (int b = 0; b < 36; b++) begin
      if (mag >= (longint'(1) << b)) p = b;
    end
    return p;
  endfunction

  function automatic logic signed [35:0] pow2(input int k, input bit neg);
    longint m;
    m = longint'(1) << k;
    return 36'(neg ? -m : m);
  endfunction

  task automatic model_init();
    m_idx = INIT_I; m_good = 0; m_dc = 0; m_oc = 0; m_uc = 0; m_total = 0;
    m_trk = 0; m_upd = 0;
    h_vld[0] = 0; h_vld[1] = 0; h_val[0] = '0; h_val[1] = '0;
  endtask

  task automatic model_apply(input logic signed [35:0] a);
    int p, ni, tgt;
    bit o, u;
    p  = msb_of(a);
    o  = (p > m_idx - 1);
    u  = (p < m_idx - 1 - UM);
    ni = m_idx;
    if (o && m_total < 65535) m_total++;
    if (!m_trk) begin
      if (o) begin
        tgt = p + 1;
        if (tgt > MAX_I) tgt = MAX_I;
        if (tgt < MIN_I) tgt = MIN_I;
        ni = tgt;
        m_good = 0;
      end else begin
        m_good++;
        if (m_good == ACQ) begin
          m_trk = 1; m_good = 0; m_dc = 0; m_oc = 0; m_uc = 0;
        end
      end
    end else begin
      m_dc++;
      if (o) m_oc++;
      if (u) m_uc++;
      if (m_dc == WIN) begin
        if (m_oc >= OVF_TH) begin
          if (m_idx + 1 <= MAX_I) ni = m_idx + 1;
        end else if (m_uc == WIN) begin
          if (m_idx - 1 >= MIN_I) ni = m_idx - 1;
        end
        m_dc = 0; m_oc = 0; m_uc = 0;
      end
    end
    m_upd = (ni != m_idx);
    m_idx = ni;
  endtask

  // One clock edge of the model: the dump presented two cycles ago is applied.
  task automatic model_edge(input bit v, input logic signed [35:0] a, input bit i);
    if (i) begin
      model_init();
    end else begin
      m_upd = 0;
      if (h_vld[1]) model_apply(h_val[1]);
      h_vld[1] = h_vld[0]; h_val[1] = h_val[0];
      h_vld[0] = v;        h_val[0] = a;
    end
  endtask

  task automatic compare_all();
    check_eq("index", 64'(index), 64'(m_idx));
    check_eq("index_update", 64'(index_update), 64'(m_upd));
    check_eq("tracking", 64'(tracking), 64'(m_trk));
`ifdef DLL_INDEX_CTRL_STATS_EN
    check_eq("ovf_total", 64'(ovf_total), 64'(m_total));
`endif
  endtask

  task automatic step(input bit v, input logic signed [35:0] a, input bit i);
    acc_valid = v; acc_in = a; init = i;
    @(posedge clk);
    model_edge(v, a, i);
    @(negedge clk);
    acc_valid = 1'b0; init = 1'b0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0);
  endtask

  task automatic dumps(input int n, input logic signed [35:0] a);
    for (int k = 0; k < n; k++) step(1'b1, a, 1'b0);
  endtask

  initial begin
    int mode;
    int lo, hi, k;
    bit v, i, neg;
    longint mag, low;

    n_chk = 0; n_fail = 0;
    reset_n = 1'b0; init = 1'b0; acc_valid = 1'b0; acc_in = '0;
    model_init();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check_eq("reset_index", 64'(index), 64'(INIT_I));
    check_eq("reset_update", 64'(index_update), 64'd0);
    check_eq("reset_tracking", 64'(tracking), 64'd0);
`ifdef DLL_INDEX_CTRL_STATS_EN
    check_eq("reset_ovf_total", 64'(ovf_total), 64'd0);
`endif

    // 1: reset mid-stream with overflow dumps in flight
    dumps(2, pow2(30, 0));
    acc_valid = 1'b1; acc_in = pow2(30, 0);
    #1 reset_n = 1'b0;
    model_init();
    #1 check_eq("t1_in_reset_index", 64'(index), 64'(INIT_I));
    check_eq("t1_in_reset_update", 64'(index_update), 64'd0);
    #1 reset_n = 1'b1;
    acc_valid = 1'b0;
    idle(4);
    check_eq("t1_after_index", 64'(index), 64'(INIT_I));

    // 2: single overflow dump in ACQUIRE, exact latency
    step(1'b1, pow2(25, 0), 1'b0);
    check_eq("t2_idx_c1", 64'(index), 64'd20);
    idle(1);
    check_eq("t2_idx_c2", 64'(index), 64'd20);
    check_eq("t2_upd_c2", 64'(index_update), 64'd0);
    idle(1);
    check_eq("t2_idx_c3", 64'(index), 64'd26);
    check_eq("t2_upd_c3", 64'(index_update), 64'd1);
    idle(1);
    check_eq("t2_upd_c4", 64'(index_update), 64'd0);

    // 3: four clean dumps -> TRACK
    dumps(4, pow2(20, 0));
    idle(3);
    check_eq("t3_tracking", 64'(tracking), 64'd1);
    check_eq("t3_index", 64'(index), 64'd26);

    // 4: under-utilised windows step down, then clamp at MIN
    dumps(8, pow2(10, 0));
    idle(3);
    check_eq("t4_idx25", 64'(index), 64'd25);
    dumps(8, pow2(10, 0));
    idle(3);
    check_eq("t4_idx24", 64'(index), 64'd24);
    dumps(14 * 8, '0);
    idle(3);
    check_eq("t4_idx_min", 64'(index), 64'(MIN_I));
    dumps(8, '0);
    idle(3);
    check_eq("t4_idx_clamped", 64'(index), 64'(MIN_I));

    // 5: overflow window in TRACK at index 20; then -2^35 in ACQUIRE
    step(1'b0, '0, 1'b1);
    dumps(4, pow2(15, 0));
    dumps(6, pow2(15, 0));
    dumps(2, pow2(20, 1));
    idle(3);
    check_eq("t5_track_inc", 64'(index), 64'd21);
    step(1'b0, '0, 1'b1);
    step(1'b1, pow2(35, 1), 1'b0);
    idle(2);
    check_eq("t5_neg_full", 64'(index), 64'd35);

    // 6: init right after an overflow dump discards it
    step(1'b0, '0, 1'b1);
    step(1'b1, pow2(30, 0), 1'b0);
    step(1'b0, '0, 1'b1);
    idle(3);
    check_eq("t6_index", 64'(index), 64'd20);
    check_eq("t6_tracking", 64'(tracking), 64'd0);

    // Randomised traffic with magnitudes biased around the current index
    mode = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) mode = $urandom_range(0, 2);
      case (mode)
        0:       begin lo = 0; hi = 8; end
        1:       begin lo = (m_idx >= 3) ? m_idx - 3 : 0; hi = m_idx - 1; end
        default: begin lo = 0; hi = 35; end
      endcase
      k    = $urandom_range(hi, lo);
      low  = {$urandom(), $urandom()};
      mag  = (longint'(1) << k) | (low & ((longint'(1) << k) - 1));
      neg  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) mag = 0;
      v = ($urandom_range(0, 3) != 0);
      i = ($urandom_range(0, 249) == 0);
      step(v, 36'(neg ? -mag : mag), i);
    end

`ifdef DLL_INDEX_CTRL_STATS_EN
    step(1'b0, '0, 1'b1);
    check_eq("t6_stats_cleared", 64'(ovf_total), 64'd0);
    step(1'b1, pow2(35, 1), 1'b0);
    dumps(65539, pow2(35, 1));
    idle(3);
    check_eq("t6_stats_saturated", 64'(ovf_total), 64'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
